// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core definitions. Holds the PC width, the canonical
//               NOP encoding (addi x0,x0,0) and the fetch-queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN      = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fq_entry_t;

endpackage
`default_nettype wire

// File: rtl/fq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fq_ctrl
// Description : Pointer, occupancy and handshake control for fetch_queue.
//               Produces the write/read pointers, the occupancy count, the
//               qualified push strobe and the full/valid flags.
// Ports       : clk, rst (async, active-low)
//               i_valid_f  - fetch presents an instruction
//               i_stall_d  - decode holds the head
//               i_flush_d  - redirect, empties the queue
//               o_push     - entry at o_wr_ptr is written this cycle
//               o_wr_ptr   - next slot to write
//               o_rd_ptr   - head slot
//               o_count    - occupancy
//               o_stall_f  - queue full
//               o_valid_d  - head entry valid
// Revision    : 1.0 - initial release
// ============================================================================
module fq_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid_f,
    input  logic                     i_stall_d,
    input  logic                     i_flush_d,
    output logic                     o_push,
    output logic [$clog2(DEPTH)-1:0] o_wr_ptr,
    output logic [$clog2(DEPTH)-1:0] o_rd_ptr,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_stall_f,
    output logic                     o_valid_d
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // Flags come from registered count only, so nothing from decode reaches
    // the fetch PC enable combinationally.
    assign w_full = (r_count == C_FULL_CNT);
    assign w_push = i_valid_f & ~w_full & ~i_flush_d;
    assign w_pop  = (r_count != '0) & ~i_stall_d & ~i_flush_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush_d) begin
            // Wrong-path redirect: drop everything; stale slot data is harmless.
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_push    = w_push;
    assign o_wr_ptr  = r_wr_ptr;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_count   = r_count;
    assign o_stall_f = w_full;
    assign o_valid_d = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction queue between fetch and decode. Captures
//               {PC_F, Instr_F} pairs and presents them to decode in order.
//               Stalls fetch when full, empties on a redirect.
// Ports       : clk, rst (async, active-low)
//               Valid_F/PC_F/Instr_F - fetch side input
//               StallF               - queue full, fetch holds its PC
//               StallD               - decode holds the head
//               FlushD               - redirect, discard all entries
//               Valid_D/PC_D/Instr_D - head entry (0 / NOP when empty)
//               Count                - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter int          XLEN  = riscv_pkg::XLEN,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Valid_F,
    input  logic [XLEN-1:0]          PC_F,
    input  logic [31:0]              Instr_F,
    output logic                     StallF,
    input  logic                     StallD,
    input  logic                     FlushD,
    output logic                     Valid_D,
    output logic [XLEN-1:0]          PC_D,
    output logic [31:0]              Instr_D,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             w_push;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic             w_valid_d;

    logic [XLEN-1:0]  r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];

    fq_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_valid_f (Valid_F),
        .i_stall_d (StallD),
        .i_flush_d (FlushD),
        .o_push    (w_push),
        .o_wr_ptr  (w_wr_ptr),
        .o_rd_ptr  (w_rd_ptr),
        .o_count   (Count),
        .o_stall_f (StallF),
        .o_valid_d (w_valid_d)
    );

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_mem_pc[i]    <= '0;
                    r_mem_instr[i] <= '0;
                end else if (w_push && (w_wr_ptr == PTR_W'(i))) begin
                    r_mem_pc[i]    <= PC_F;
                    r_mem_instr[i] <= Instr_F;
                end
            end
        end
    endgenerate

    // Head is read straight from the array; an empty queue shows a bubble.
    assign Valid_D = w_valid_d;
    assign PC_D    = w_valid_d ? r_mem_pc[w_rd_ptr]    : '0;
    assign Instr_D = w_valid_d ? r_mem_instr[w_rd_ptr] : NOP;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic            clk;
    logic            rst;
    logic            Valid_F;
    logic [XLEN-1:0] PC_F;
    logic [31:0]     Instr_F;
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            Valid_D;
    logic [XLEN-1:0] PC_D;
    logic [31:0]     Instr_D;
    logic [2:0]      Count;

    int errors = 0;
    int checks = 0;

    fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .NOP   (32'h0000_0013)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Valid_F (Valid_F),
        .PC_F    (PC_F),
        .Instr_F (Instr_F),
        .StallF  (StallF),
        .StallD  (StallD),
        .FlushD  (FlushD),
        .Valid_D (Valid_D),
        .PC_D    (PC_D),
        .Instr_D (Instr_D),
        .Count   (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [63:0] pc);
        return 32'hC000_0000 | pc[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic vf, input logic [63:0] pc, input logic sd, input logic fl);
        Valid_F = vf;
        PC_F    = pc;
        Instr_F = ins(pc);
        StallD  = sd;
        FlushD  = fl;
    endtask

    task automatic head(input string tag, input logic [63:0] pc, input int cnt);
        chk({tag, ".count"}, 64'(Count), 64'(cnt));
        chk({tag, ".valid"}, 64'(Valid_D), (cnt != 0) ? 64'd1 : 64'd0);
        chk({tag, ".pc"}, PC_D, (cnt != 0) ? pc : 64'd0);
        chk({tag, ".instr"}, 64'(Instr_D), (cnt != 0) ? 64'(ins(pc)) : 64'h13);
    endtask

    initial begin
        logic [63:0] sb[$];
        logic [63:0] np;
        logic        pat_v [10];
        logic        pat_s [10];
        logic        p_push;
        logic        p_pop;

        rst = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        #1;
        head("reset", 64'h0, 0);
        chk("reset.stallf", 64'(StallF), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        head("idle", 64'h0, 0);

        // Fill with decode stalled.
        drive(1'b1, 64'h0, 1'b1, 1'b0);  cyc(); head("fill0", 64'h0, 1);
        drive(1'b1, 64'h4, 1'b1, 1'b0);  cyc(); head("fill1", 64'h0, 2);
        drive(1'b1, 64'h8, 1'b1, 1'b0);  cyc(); head("fill2", 64'h0, 3);
        chk("fill2.stallf", 64'(StallF), 64'd0);
        drive(1'b1, 64'hC, 1'b1, 1'b0);  cyc(); head("fill3", 64'h0, 4);
        chk("fill3.stallf", 64'(StallF), 64'd1);
        drive(1'b1, 64'h10, 1'b1, 1'b0); cyc(); head("full_hold", 64'h0, 4);
        chk("full_hold.stallf", 64'(StallF), 64'd1);
        // Full with decode consuming: pop happens, push blocked.
        drive(1'b1, 64'h10, 1'b0, 1'b0); cyc(); head("full_pop", 64'h4, 3);
        chk("full_pop.stallf", 64'(StallF), 64'd0);
        drive(1'b1, 64'h10, 1'b0, 1'b0); cyc(); head("drain0", 64'h8, 3);
        drive(1'b0, 64'h0, 1'b0, 1'b0);  cyc(); head("drain1", 64'hC, 2);
        cyc(); head("drain2", 64'h10, 1);
        cyc(); head("drain3", 64'h0, 0);

        // Streaming: head lags fetch by one cycle, occupancy stays 1.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'h20 + 64'(4 * i), 1'b0, 1'b0);
            cyc();
            head("stream", 64'h20 + 64'(4 * i), 1);
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0); cyc(); head("stream_end", 64'h0, 0);

        // Flush at Count=3 with a same-cycle push that must be discarded.
        drive(1'b1, 64'h30, 1'b1, 1'b0); cyc();
        drive(1'b1, 64'h34, 1'b1, 1'b0); cyc();
        drive(1'b1, 64'h38, 1'b1, 1'b0); cyc(); head("pre_flush", 64'h30, 3);
        drive(1'b1, 64'h100, 1'b0, 1'b1); cyc(); head("flush", 64'h0, 0);
        drive(1'b1, 64'h200, 1'b1, 1'b0); cyc(); head("post_flush", 64'h200, 1);
        drive(1'b0, 64'h0, 1'b1, 1'b0);   cyc(); head("post_flush_hold", 64'h200, 1);
        drive(1'b0, 64'h0, 1'b0, 1'b0);   cyc(); head("post_flush_pop", 64'h0, 0);

        // Flush while full: StallF must drop next cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h40 + 64'(4 * i), 1'b1, 1'b0);
            cyc();
        end
        chk("full_flush.pre_stallf", 64'(StallF), 64'd1);
        drive(1'b0, 64'h0, 1'b1, 1'b1); cyc(); head("full_flush", 64'h0, 0);
        chk("full_flush.stallf", 64'(StallF), 64'd0);
        drive(1'b0, 64'h0, 1'b0, 1'b0); cyc(); head("full_flush_idle", 64'h0, 0);

        // Mixed push/pop across pointer wrap against a scoreboard.
        pat_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        pat_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        np = 64'h300;
        for (int i = 0; i < 10; i++) begin
            drive(pat_v[i], np, pat_s[i], 1'b0);
            p_push = pat_v[i] && (sb.size() < DEPTH);
            p_pop  = (sb.size() > 0) && !pat_s[i];
            cyc();
            if (p_pop)  void'(sb.pop_front());
            if (p_push) begin
                sb.push_back(np);
                np = np + 64'h4;
            end
            head("wrap", (sb.size() > 0) ? sb[0] : 64'h0, sb.size());
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 64'h0, 1'b0, 1'b0);
            if (sb.size() > 0) void'(sb.pop_front());
            cyc();
            head("wrap_drain", (sb.size() > 0) ? sb[0] : 64'h0, sb.size());
        end

        // Asynchronous reset mid-cycle with Count=3.
        drive(1'b1, 64'h500, 1'b1, 1'b0); cyc();
        drive(1'b1, 64'h504, 1'b1, 1'b0); cyc();
        drive(1'b1, 64'h508, 1'b1, 1'b0); cyc(); head("pre_rst", 64'h500, 3);
        #2;
        rst = 1'b0;
        #1;
        head("async_rst", 64'h0, 0);
        chk("async_rst.stallf", 64'(StallF), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        cyc();
        head("after_rst", 64'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
